// File: rtl/bcd_updown_counter_n_pkg.sv
// Shared BCD constants and helpers for the N-digit up/down counter.
package bcd_updown_counter_n_pkg;
   localparam int         BCD_W    = 4;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   // Non-decimal nibbles (A..F) saturate to 9 on load.
   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction
endpackage

// File: rtl/bcd_updown_counter_n_if.sv
// Control/status bundle between the button pulse chain and the BCD counter.
interface bcd_updown_counter_n_if #(parameter int DIGITS = 4);
   logic                clear;
   logic                set9;
   logic                load;
   logic [4*DIGITS-1:0] load_value;
   logic [DIGITS-1:0]   up;
   logic [DIGITS-1:0]   down;
   logic                wrap_en;
   logic [4*DIGITS-1:0] value;
   logic                at_max;
   logic                at_min;
   logic                overflow;
   logic                underflow;

   modport master (
      output clear, set9, load, load_value, up, down, wrap_en,
      input  value, at_max, at_min, overflow, underflow
   );

   modport slave (
      input  clear, set9, load, load_value, up, down, wrap_en,
      output value, at_max, at_min, overflow, underflow
   );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit: register plus combinational increment/decrement with carry/borrow.
module bcd_digit_cell
   import bcd_updown_counter_n_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             clear,
   input  logic             set9,
   input  logic             load,
   input  logic [BCD_W-1:0] load_digit,
   input  logic             commit,
   output logic [BCD_W-1:0] digit,
   output logic             is9,
   output logic             is0,
   output logic             carry_out,
   output logic             borrow_out
);
   logic [BCD_W-1:0] digit_reg;
   logic [BCD_W-1:0] digit_next;
   logic             is9_reg;
   logic             is0_reg;

   always_comb begin
      digit_next = digit_reg;
      if (clear)
         digit_next = BCD_ZERO;
      else if (set9)
         digit_next = BCD_MAX;
      else if (load)
         digit_next = bcd_clamp(load_digit);
      else if (commit && inc)
         digit_next = is9_reg ? BCD_ZERO : digit_reg + 4'd1;
      else if (commit && dec)
         digit_next = is0_reg ? BCD_MAX : digit_reg - 4'd1;
   end

   // The 9/0 flags are registered from the next-state digit so they line up with digit_reg.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digit_reg <= BCD_ZERO;
         is9_reg   <= 1'b0;
         is0_reg   <= 1'b1;
      end else begin
         digit_reg <= digit_next;
         is9_reg   <= (digit_next == BCD_MAX);
         is0_reg   <= (digit_next == BCD_ZERO);
      end
   end

   assign digit      = digit_reg;
   assign is9        = is9_reg;
   assign is0        = is0_reg;
   assign carry_out  = inc & is9_reg;
   assign borrow_out = dec & is0_reg;
endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with per-digit steps, saturate/wrap mode, load and flags.
module bcd_updown_counter_n
   import bcd_updown_counter_n_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   bcd_updown_counter_n_if.slave  bus
);
   logic [DIGITS-1:0] up_sel;
   logic [DIGITS-1:0] down_sel;
   logic [DIGITS-1:0] inc;
   logic [DIGITS-1:0] dec;
   logic [DIGITS-1:0] carry;
   logic [DIGITS-1:0] borrow;
   logic [DIGITS-1:0] is9;
   logic [DIGITS-1:0] is0;
   logic              step_up;
   logic              step_down;
   logic              ctrl_any;
   logic              top_carry;
   logic              top_borrow;
   logic              commit;
   logic              overflow_reg;
   logic              underflow_reg;

   // Simultaneous up and down requests cancel; otherwise the lowest set bit is isolated.
   assign step_up   = (|bus.up) & ~(|bus.down);
   assign step_down = (|bus.down) & ~(|bus.up);
   assign up_sel    = step_up   ? (bus.up   & (~bus.up   + DIGITS'(1))) : '0;
   assign down_sel  = step_down ? (bus.down & (~bus.down + DIGITS'(1))) : '0;

   assign ctrl_any   = bus.clear | bus.set9 | bus.load;
   assign top_carry  = carry[DIGITS-1];
   assign top_borrow = borrow[DIGITS-1];
   assign commit     = ~((top_carry | top_borrow) & ~bus.wrap_en);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign inc[gi] = up_sel[gi];
            assign dec[gi] = down_sel[gi];
         end else begin : g_chain
            assign inc[gi] = up_sel[gi]   | carry[gi-1];
            assign dec[gi] = down_sel[gi] | borrow[gi-1];
         end

         bcd_digit_cell u_cell (
            .clock      (clock),
            .reset      (reset),
            .inc        (inc[gi]),
            .dec        (dec[gi]),
            .clear      (bus.clear),
            .set9       (bus.set9),
            .load       (bus.load),
            .load_digit (bus.load_value[gi*BCD_W +: BCD_W]),
            .commit     (commit),
            .digit      (bus.value[gi*BCD_W +: BCD_W]),
            .is9        (is9[gi]),
            .is0        (is0[gi]),
            .carry_out  (carry[gi]),
            .borrow_out (borrow[gi])
         );
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         overflow_reg  <= top_carry  & ~ctrl_any;
         underflow_reg <= top_borrow & ~ctrl_any;
      end
   end

   assign bus.at_max    = &is9;
   assign bus.at_min    = &is0;
   assign bus.overflow  = overflow_reg;
   assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Randomized self-checking bench for bcd_updown_counter_n against an integer reference model.
module tb_bcd_updown_counter_n;
   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = 9999;
   localparam int MODV   = 10000;

   logic clock;
   logic reset;
   bcd_updown_counter_n_if #(.DIGITS(DIGITS)) bus ();

   bcd_updown_counter_n #(.DIGITS(DIGITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks;
   int n_pass;
   int model_val;
   bit model_ov;
   bit model_un;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] b;
      int t;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         b[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction

   function automatic int pow10(input int k);
      int p;
      p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   function automatic int lowest_bit(input logic [DIGITS-1:0] r);
      for (int i = 0; i < DIGITS; i++)
         if (r[i]) return i;
      return 0;
   endfunction

   task automatic model_step(input bit c, input bit s9, input bit ld, input logic [W-1:0] lv,
                             input logic [DIGITS-1:0] u, input logic [DIGITS-1:0] d, input bit w);
      int n;
      int dg;
      model_ov = 0;
      model_un = 0;
      if (c) model_val = 0;
      else if (s9) model_val = MAXV;
      else if (ld) begin
         model_val = 0;
         for (int i = 0; i < DIGITS; i++) begin
            dg = int'(lv[i*4 +: 4]);
            if (dg > 9) dg = 9;
            model_val += dg * pow10(i);
         end
      end else if (u != 0 && d != 0) begin
      end else if (u != 0) begin
         n = model_val + pow10(lowest_bit(u));
         if (n > MAXV) begin
            model_ov = 1;
            if (w) model_val = n - MODV;
         end else model_val = n;
      end else if (d != 0) begin
         n = model_val - pow10(lowest_bit(d));
         if (n < 0) begin
            model_un = 1;
            if (w) model_val = n + MODV;
         end else model_val = n;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".value"},     32'(bus.value),     32'(to_bcd(model_val)));
      check({tag, ".at_max"},    32'(bus.at_max),    32'(model_val == MAXV));
      check({tag, ".at_min"},    32'(bus.at_min),    32'(model_val == 0));
      check({tag, ".overflow"},  32'(bus.overflow),  32'(model_ov));
      check({tag, ".underflow"}, 32'(bus.underflow), 32'(model_un));
   endtask

   task automatic do_cycle(input string tag, input bit c, input bit s9, input bit ld,
                           input logic [W-1:0] lv, input logic [DIGITS-1:0] u,
                           input logic [DIGITS-1:0] d, input bit w);
      bus.clear = c; bus.set9 = s9; bus.load = ld; bus.load_value = lv;
      bus.up = u; bus.down = d; bus.wrap_en = w;
      @(posedge clock);
      #1;
      model_step(c, s9, ld, lv, u, d, w);
      $display("cyc %s clr=%0b s9=%0b ld=%0b lv=%h up=%b dn=%b wrap=%0b -> value=%h ov=%0b un=%0b",
               tag, c, s9, ld, lv, u, d, w, bus.value, bus.overflow, bus.underflow);
      check_outputs(tag);
      bus.clear = 0; bus.set9 = 0; bus.load = 0; bus.up = '0; bus.down = '0;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      model_val = 0; model_ov = 0; model_un = 0;
      bus.clear = 0; bus.set9 = 0; bus.load = 0; bus.load_value = '0;
      bus.up = '0; bus.down = '0; bus.wrap_en = 0;
      reset = 1'b1;
      #12;
      check_outputs("reset");
      @(negedge clock);
      reset = 1'b0;

      do_cycle("ld0999",   0, 0, 1, 16'h0999, 4'b0000, 4'b0000, 0);
      do_cycle("up_ripl",  0, 0, 0, 16'h0000, 4'b0001, 4'b0000, 0);
      check("lit1000", 32'(bus.value), 32'h1000);
      do_cycle("ld9995",   0, 0, 1, 16'h9995, 4'b0000, 4'b0000, 0);
      do_cycle("ov_sat",   0, 0, 0, 16'h0000, 4'b0010, 4'b0000, 0);
      check("lit9995", 32'(bus.value), 32'h9995);
      do_cycle("ov_idle",  0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0);
      do_cycle("ov_wrap",  0, 0, 0, 16'h0000, 4'b0010, 4'b0000, 1);
      check("lit0005", 32'(bus.value), 32'h0005);
      do_cycle("ld0003",   0, 0, 1, 16'h0003, 4'b0000, 4'b0000, 1);
      do_cycle("un_wrap",  0, 0, 0, 16'h0000, 4'b0000, 4'b0100, 1);
      check("lit9903", 32'(bus.value), 32'h9903);
      do_cycle("un_idle",  0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 1);
      do_cycle("ld0003b",  0, 0, 1, 16'h0003, 4'b0000, 4'b0000, 0);
      do_cycle("un_sat",   0, 0, 0, 16'h0000, 4'b0000, 4'b0100, 0);
      do_cycle("clr",      1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0);
      do_cycle("lowidx",   0, 0, 0, 16'h0000, 4'b0110, 4'b0000, 0);
      check("lit0010", 32'(bus.value), 32'h0010);
      do_cycle("updn",     0, 0, 0, 16'h0000, 4'b0001, 4'b0001, 0);
      do_cycle("ldclamp",  0, 0, 1, 16'hA5C3, 4'b0000, 4'b0000, 0);
      check("lit9593", 32'(bus.value), 32'h9593);
      do_cycle("s9clr",    1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 0);
      do_cycle("set9",     0, 1, 0, 16'h0000, 4'b0000, 4'b0000, 0);
      do_cycle("ldstep",   0, 0, 1, 16'h0042, 4'b0001, 4'b0000, 0);
      do_cycle("ld4321",   0, 0, 1, 16'h4321, 4'b0000, 4'b0000, 0);

      // Asynchronous reset between edges: outputs must clear before the next edge.
      #2;
      reset = 1'b1;
      #1;
      model_val = 0; model_ov = 0; model_un = 0;
      check_outputs("async_rst");
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 400; i++) begin
         int r, mode;
         bit c, s9, ld, w;
         logic [W-1:0] lv;
         logic [DIGITS-1:0] u, d;
         r = int'($urandom_range(0, 99));
         c  = (r < 3);
         s9 = (r >= 3 && r < 7) || (r == 50);
         ld = (r >= 7 && r < 16) || (r == 51);
         lv = W'($urandom);
         w  = 1'($urandom);
         mode = int'($urandom_range(0, 9));
         u = '0; d = '0;
         if (mode < 4) u = DIGITS'($urandom_range(1, 15));
         else if (mode < 8) d = DIGITS'($urandom_range(1, 15));
         else if (mode == 8) begin
            u = DIGITS'($urandom_range(1, 15));
            d = DIGITS'($urandom_range(1, 15));
         end
         do_cycle("rand", c, s9, ld, lv, u, d, w);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
